// File: rtl/apb_arb_master.sv
// Two-requester round-robin arbiter driving an APB master (two slaves, selected by PADDR[AW-1]).
// Latency: accept at edge 0, SETUP cycle 1, ACCESS cycle 2+, done pulse the cycle after PREADY or timeout.
// Backpressure: reqN_ready is offered only in IDLE; PREADY=0 stretches ACCESS up to TIMEOUT cycles, then aborts.
module apb_arb_master #(
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          req0_valid,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_done,
    output logic [DW-1:0] req0_rdata,
    output logic          req0_err,
    input  logic          req1_valid,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_done,
    output logic [DW-1:0] req1_rdata,
    output logic          req1_err,
    output logic          PSEL1,
    output logic          PSEL2,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA1,
    input  logic [DW-1:0] PRDATA2,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;      // 1: req1 wins a tie, 0: req0 wins a tie
    logic          id_q, id_d;          // requester owning the transfer in flight
    logic [7:0]    cnt_q, cnt_d;        // PREADY=0 cycles already spent in ACCESS
    logic          psel1_q, psel1_d, psel2_q, psel2_d, penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic          done0_q, done0_d, done1_q, done1_d, err0_q, err0_d, err1_q, err1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic          grant0, grant1, accept, acc_id, acc_write;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata, cap_rdata, fin_rdata;
    logic          fin, fin_err;

    // A lone requester always wins; on a tie the pointer decides.
    assign grant0     = req0_valid & (~req1_valid | ~prio_q);
    assign grant1     = req1_valid & (~req0_valid |  prio_q);
    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;
    assign acc_id     = req1_ready;
    assign acc_write  = acc_id ? req1_write : req0_write;
    assign acc_addr   = acc_id ? req1_addr  : req0_addr;
    assign acc_wdata  = acc_id ? req1_wdata : req0_wdata;
    // Read data comes from whichever slave the latched address selects; writes return zero.
    assign cap_rdata  = pwrite_q ? '0 : (paddr_q[AW-1] ? PRDATA2 : PRDATA1);

    assign PSEL1      = psel1_q;
    assign PSEL2      = psel2_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign req0_done  = done0_q;
    assign req1_done  = done1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign req0_err   = err0_q;
    assign req1_err   = err1_q;

    // Next-state logic: sequence IDLE -> SETUP -> ACCESS and build the registered APB/completion outputs.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        psel1_d   = psel1_q;
        psel2_d   = psel2_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata0_d  = '0;
        rdata1_d  = '0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        fin       = 1'b0;
        fin_err   = 1'b0;
        fin_rdata = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d      = acc_id;
                    prio_d    = ~acc_id;
                    pwrite_d  = acc_write;
                    paddr_d   = acc_addr;
                    pwdata_d  = acc_write ? acc_wdata : '0;
                    psel1_d   = ~acc_addr[AW-1];
                    psel2_d   = acc_addr[AW-1];
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    fin       = 1'b1;
                    fin_rdata = cap_rdata;
                    fin_err   = PSLVERR;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (fin) begin
                    psel1_d   = 1'b0;
                    psel2_d   = 1'b0;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            if (id_q) begin
                done1_d  = 1'b1;
                rdata1_d = fin_rdata;
                err1_d   = fin_err;
            end else begin
                done0_d  = 1'b1;
                rdata0_d = fin_rdata;
                err0_d   = fin_err;
            end
        end
    end

    // State and output registers; reset drops everything and favours req0.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            id_q      <= 1'b0;
            cnt_q     <= '0;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            psel1_q   <= psel1_d;
            psel2_q   <= psel2_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Self-checking bench for apb_arb_master: directed transfer table, corner sequences, randomized run vs reference model.
// Latency: checks the accept/SETUP/ACCESS/done timeline cycle by cycle.
// Backpressure: exercises PREADY wait states, timeout aborts and requester withdrawal.
module tb_apb_arb_master;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int TIMEOUT = 16;

    logic PCLK = 1'b0;
    logic PRESETn;
    always #5 PCLK = ~PCLK;

    logic          rv[2], rw[2];
    logic [AW-1:0] ra[2];
    logic [DW-1:0] rwd[2];
    logic          req0_valid, req0_write, req1_valid, req1_write;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          PSEL1, PSEL2, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA1, PRDATA2;

    assign req0_valid = rv[0];
    assign req0_write = rw[0];
    assign req0_addr  = ra[0];
    assign req0_wdata = rwd[0];
    assign req1_valid = rv[1];
    assign req1_write = rw[1];
    assign req1_addr  = ra[1];
    assign req1_wdata = rwd[1];

    apb_arb_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_prints = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_prints < 30) begin
                n_prints++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
            end
        end
    endtask

    typedef struct {
        bit            id;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] prdata;
        int            waits;
        bit            slverr;
        bit            e_sel1;
        bit            e_sel2;
        logic [DW-1:0] e_pwdata;
        logic [DW-1:0] e_rdata;
        bit            e_err;
    } vec_t;

    vec_t tbl[6];

    task automatic clr_inputs();
        for (int n = 0; n < 2; n++) begin
            rv[n] = 1'b0; rw[n] = 1'b0; ra[n] = '0; rwd[n] = '0;
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA1 = '0; PRDATA2 = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    // One isolated transfer from a single requester, checked at every cycle of its timeline.
    task automatic do_xfer(input vec_t v);
        @(negedge PCLK);
        rv[v.id] = 1'b1; rw[v.id] = v.wr; ra[v.id] = v.addr; rwd[v.id] = v.wdata; rv[!v.id] = 1'b0;
        PREADY = 1'b0; PSLVERR = 1'b0;
        PRDATA1 = v.addr[AW-1] ? ~v.prdata : v.prdata;
        PRDATA2 = v.addr[AW-1] ? v.prdata : ~v.prdata;
        #1 check("xfer ready", v.id ? req1_ready : req0_ready, 1);
        @(negedge PCLK);
        rv[v.id] = 1'b0; PREADY = 1'b1; PSLVERR = 1'b1;   // must be ignored during SETUP
        #1;
        check("setup sel", {PSEL1, PSEL2, PENABLE}, {v.e_sel1, v.e_sel2, 1'b0});
        check("setup paddr", PADDR, v.addr);
        check("setup pwrite", PWRITE, v.wr);
        check("setup pwdata", PWDATA, v.e_pwdata);
        for (int k = 0; k < v.waits; k++) begin
            @(negedge PCLK);
            PREADY = 1'b0; PSLVERR = 1'b0;
            #1 check("wait hold", {PSEL1, PSEL2, PENABLE, req0_done, req1_done}, {v.e_sel1, v.e_sel2, 1'b1, 2'b00});
        end
        @(negedge PCLK);
        PREADY = 1'b1; PSLVERR = v.slverr;
        #1 check("access", {PSEL1, PSEL2, PENABLE, PADDR, PWDATA}, {v.e_sel1, v.e_sel2, 1'b1, v.addr, v.e_pwdata});
        @(negedge PCLK);
        PREADY = 1'b0; PSLVERR = 1'b0;
        #1;
        check("done pulse", {req0_done, req1_done}, v.id ? 2'b01 : 2'b10);
        check("done rdata", v.id ? req1_rdata : req0_rdata, v.e_rdata);
        check("done err", v.id ? req1_err : req0_err, v.e_err);
        check("other quiet", v.id ? {req0_rdata, req0_err} : {req1_rdata, req1_err}, 0);
        check("apb released", {PSEL1, PSEL2, PENABLE}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // reference model state for the randomized section
    bit            m_busy, m_id, m_wr, m_last, win, e_rdy0, e_rdy1, fin, f_err;
    int            m_age, first, ng, mode;
    logic [AW-1:0] m_addr, x_addr;
    logic [DW-1:0] m_wdata, x_wdata, f_rd;
    logic          x_wr;
    bit            e_done[2], e_err[2], acc[2];
    logic [DW-1:0] e_rd[2];
    logic [42:0]   got, exp;
    bit            pen17, saw_done, both;
    int            g[4];

    initial begin
        tbl[0] = '{1'b0, 1'b1, 9'h012, 8'hA5, 8'h77, 0,  1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 9'h105, 8'h99, 8'h3C, 2,  1'b0, 1'b0, 1'b1, 8'h00, 8'h3C, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 9'h1FF, 8'h11, 8'hC3, 0,  1'b1, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 9'h0AA, 8'h5A, 8'h66, 1,  1'b1, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 9'h000, 8'hFF, 8'h81, 3,  1'b0, 1'b1, 1'b0, 8'h00, 8'h81, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 9'h100, 8'h42, 8'hE7, 15, 1'b0, 1'b0, 1'b1, 8'h00, 8'hE7, 1'b0};

        do_reset();
        #1 check("reset outputs", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, req0_ready, req1_ready,
                                   req0_done, req1_done, req0_rdata, req1_rdata, req0_err, req1_err}, 0);

        for (int i = 0; i < 6; i++) do_xfer(tbl[i]);

        // Timeout: PREADY never rises; abort after TIMEOUT ACCESS cycles, done in cycle TIMEOUT+2.
        @(negedge PCLK);
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 9'h034; PREADY = 1'b0; PRDATA1 = 8'h5E;
        first = -1; pen17 = 1'b0;
        for (int c = 1; c <= 40 && first < 0; c++) begin
            @(negedge PCLK);
            if (c == 1) rv[0] = 1'b0;
            #1;
            if (c == TIMEOUT + 1) pen17 = PENABLE;
            if (req0_done) begin
                first = c;
                check("timeout err", req0_err, 1);
                check("timeout rdata", req0_rdata, 0);
                check("timeout released", {PSEL1, PSEL2, PENABLE}, 0);
            end
        end
        check("timeout done cycle", first, TIMEOUT + 2);
        check("timeout last access", pen17, 1);

        // Reset asserted in ACCESS: outputs clear at once, no done afterwards.
        @(negedge PCLK);
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 9'h1AA; PREADY = 1'b0;
        @(negedge PCLK);
        rv[1] = 1'b0;
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1 check("async reset", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        @(negedge PCLK);
        #2 PRESETn = 1'b1;
        PREADY = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge PCLK);
            #1 saw_done = saw_done | req0_done | req1_done;
        end
        check("no done after reset", saw_done, 0);

        // Withdrawal before acceptance leaves no trace (pointer included).
        @(negedge PCLK);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 9'h0F0; rwd[0] = 8'h03;
        #1 check("withdraw ready", req0_ready, 1);
        #2 rv[0] = 1'b0;
        @(negedge PCLK);
        #1 check("withdraw no xfer", {PSEL1, PSEL2, PENABLE, req0_ready}, 0);

        // Both requesters continuously valid: grants alternate, starting with req0.
        @(negedge PCLK);
        rv[0] = 1'b1; rv[1] = 1'b1; rw[0] = 1'b1; rw[1] = 1'b0; ra[0] = 9'h011; ra[1] = 9'h122; PREADY = 1'b1;
        ng = 0; both = 1'b0;
        for (int i = 0; i < 4; i++) g[i] = 2;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if (req0_ready && req1_ready) both = 1'b1;
            else if (req0_ready) begin g[ng] = 0; ng++; end
            else if (req1_ready) begin g[ng] = 1; ng++; end
            @(negedge PCLK);
        end
        rv[0] = 1'b0; rv[1] = 1'b0;
        check("alt grants", ng, 4);
        check("alt exclusive", both, 0);
        for (int i = 0; i < 4; i++) check($sformatf("alt grant %0d", i), g[i], i % 2);

        // Randomized run against a transaction-timeline model.
        do_reset();
        m_busy = 1'b0; m_last = 1'b1; m_age = 0;
        for (int n = 0; n < 2; n++) begin e_done[n] = 0; e_err[n] = 0; e_rd[n] = '0; acc[n] = 0; end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge PCLK);
            mode = (cyc / 200) % 3;
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) rv[n] = 1'b0;
                acc[n] = 1'b0;
                if (!rv[n] && $urandom_range(0, 2) == 0) begin
                    rv[n] = 1'b1; rw[n] = 1'($urandom_range(0, 1)); ra[n] = AW'($urandom); rwd[n] = DW'($urandom);
                end else if (rv[n] && $urandom_range(0, 19) == 0) begin
                    rv[n] = 1'b0;
                end
            end
            PREADY  = (mode == 0) ? ($urandom_range(0, 3) != 0) : (mode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
            PSLVERR = ($urandom_range(0, 3) == 0);
            PRDATA1 = DW'($urandom);
            PRDATA2 = DW'($urandom);
            #1;
            win    = (rv[0] && rv[1]) ? ~m_last : rv[1];
            e_rdy0 = !m_busy && rv[0] && !win;
            e_rdy1 = !m_busy && rv[1] && win;
            x_wr    = m_busy ? m_wr : 1'b0;
            x_addr  = m_busy ? m_addr : '0;
            x_wdata = (m_busy && m_wr) ? m_wdata : '0;
            exp = {m_busy && !m_addr[AW-1], m_busy && m_addr[AW-1], m_busy && m_age >= 2, x_wr, x_addr, x_wdata,
                   e_rdy0, e_rdy1, e_done[0], e_done[1], e_rd[0], e_rd[1], e_err[0], e_err[1]};
            x_wr    = m_busy ? PWRITE : 1'b0;
            x_addr  = m_busy ? PADDR : '0;
            x_wdata = m_busy ? PWDATA : '0;
            got = {PSEL1, PSEL2, PENABLE, x_wr, x_addr, x_wdata, req0_ready, req1_ready, req0_done, req1_done,
                   req0_rdata, req1_rdata, req0_err, req1_err};
            check($sformatf("random cycle %0d", cyc), got, exp);
            // advance the model across the coming rising edge
            for (int n = 0; n < 2; n++) begin e_done[n] = 0; e_err[n] = 0; e_rd[n] = '0; end
            fin = 1'b0; f_err = 1'b0; f_rd = '0;
            if (m_busy && m_age >= 2) begin
                if (PREADY) begin
                    fin = 1'b1; f_err = PSLVERR;
                    f_rd = m_wr ? 8'h00 : (m_addr[AW-1] ? PRDATA2 : PRDATA1);
                end else if (m_age - 1 == TIMEOUT) begin
                    fin = 1'b1; f_err = 1'b1;
                end else m_age++;
            end else if (m_busy) begin
                m_age++;
            end else if (e_rdy0 || e_rdy1) begin
                m_id = e_rdy1; m_wr = rw[m_id]; m_addr = ra[m_id]; m_wdata = rwd[m_id];
                m_last = m_id; m_busy = 1'b1; m_age = 1; acc[m_id] = 1'b1;
            end
            if (fin) begin
                e_done[m_id] = 1'b1; e_rd[m_id] = f_rd; e_err[m_id] = f_err; m_busy = 1'b0;
            end
        end

        if (n_fail == 0)
            $display("PASS: %0d/%0d checks passed", n_pass, n_chk);
        else
            $display("FAIL: %0d of %0d checks failed", n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter AW, 9, address width; bit AW-1 selects the slave.
REQ-002 Parameter DW, 8, data width.
REQ-003 Parameter TIMEOUT, 16, maximum ACCESS wait cycles before abort (range 2..255).
REQ-004 PCLK  in  1  single clock; all state updates on its rising edge.
REQ-005 PRESETn  in  1  asynchronous, active-low reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1) has a transfer pending; held until accepted.
REQ-007 reqN_write  in  1  1 = write, 0 = read; stable while reqN_valid.
REQ-008 reqN_addr  in  AW  transfer address; stable while reqN_valid.
REQ-009 reqN_wdata  in  DW  write data; stable while reqN_valid.
REQ-010 reqN_ready  out  1  acceptance strobe; a transfer is accepted on the edge where valid & ready.
REQ-011 reqN_done  out  1  one-cycle completion pulse.
REQ-012 reqN_rdata  out  DW  read data; valid only while reqN_done is high.
REQ-013 reqN_err  out  1  slave error or timeout; valid only while reqN_done is high.
REQ-014 PSEL1, PSEL2  out  1 each  slave selects.
REQ-015 PENABLE  out  1  APB access phase.
REQ-016 PWRITE  out  1  APB direction.
REQ-017 PADDR  out  AW  APB address.
REQ-018 PWDATA  out  DW  APB write data.
REQ-019 PRDATA1, PRDATA2  in  DW each  slave read data.
REQ-020 PREADY  in  1  wait/complete from the selected slave.
REQ-021 PSLVERR  in  1  slave error, sampled only with PREADY.

Function
REQ-022 The FSM SHALL have the states IDLE, SETUP and ACCESS; all APB outputs are registered.
REQ-023 In IDLE, reqN_ready SHALL be high only for the granted requester; it is combinational from the state, valid and the pointer.
REQ-024 Arbitration SHALL be round-robin: if both requesters are valid, the one not granted last wins; a single valid requester always wins.
REQ-025 The priority pointer SHALL update only on acceptance.
REQ-026 On acceptance, the block SHALL latch write/addr/wdata/requester ID and move to SETUP.
REQ-027 SETUP (one cycle): PSEL1 = ~addr[AW-1], PSEL2 = addr[AW-1], PENABLE=0; PADDR/PWRITE/PWDATA = latched values.
REQ-028 In SETUP, PWDATA SHALL be 0 for reads.
REQ-029 ACCESS: PENABLE=1; PSEL and PADDR/PWRITE/PWDATA are held.
REQ-030 The FSM SHALL remain in ACCESS while PREADY=0.
REQ-031 On PREADY=1 the block SHALL capture PRDATA of the selected slave (0 for writes) and PSLVERR, drop PSEL/PENABLE, and return to IDLE.
REQ-032 reqN_done SHALL pulse in the cycle after PREADY was sampled, with rdata/err valid in that cycle.
REQ-033 Latency for a zero-wait transfer SHALL be: accept at edge 0, SETUP cycle 1, ACCESS cycle 2, done cycle 3.
REQ-034 A new acceptance MAY occur in the done cycle; transfers are therefore at least 3 cycles apart.
REQ-035 Timeout: if PREADY stays 0 for TIMEOUT consecutive ACCESS cycles, the block SHALL abort to IDLE, drop PSEL/PENABLE, and pulse done with err=1, rdata=0.
REQ-036 The timeout counter SHALL clear on entry to ACCESS.
REQ-037 PREADY and PSLVERR SHALL be ignored outside ACCESS.
REQ-038 Only the granted requester's done/rdata/err SHALL change; the other requester's done, rdata and err SHALL stay 0.
REQ-039 reqN_valid dropping before acceptance SHALL withdraw the request with no side effects.

Reset
REQ-040 PRESETn low SHALL immediately force IDLE, all APB outputs 0, done/rdata/err 0, pointer favouring req0, and timeout counter 0.
REQ-041 Reset mid-transfer SHALL silently discard the transfer; no done pulse is issued after release.
REQ-042 The first grant after reset release SHALL follow REQ-024 with req0 favoured.

Verification
REQ-043 Write req0 addr 0x012 data 0xA5, PREADY=1 -> PSEL1=1 cycle 1, PENABLE=1 cycle 2, req0_done cycle 3, err=0.
REQ-044 Read req1 addr 0x105, PRDATA2=0x3C, PREADY low 2 cycles -> PSEL2 held 4 cycles, req1_rdata=0x3C with done.
REQ-045 Both requesters continuously valid -> grants alternate 0,1,0,1; no requester starves.
REQ-046 PREADY held 0 with TIMEOUT=16 -> abort after 16 ACCESS cycles, done with err=1, rdata=0x00.
REQ-047 PSLVERR=1 with PREADY on a read -> err=1, rdata=captured PRDATA.
REQ-048 PRESETn asserted during ACCESS -> outputs 0 asynchronously, no done pulse after release, next grant to req0.
